// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// The control unit stalls the pipeline while this unit is busy. Operands are
// latched on an accepted start, one bit is processed per clock, and the
// result is registered in a final fix-up cycle together with a one-cycle
// done pulse.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   start      request, accepted only while ready
//   Operation  RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   SrcA       rs1: multiplicand / dividend
//   SrcB       rs2: multiplier / divisor
//   ready      unit is idle and can accept start
//   busy       operation in flight
//   done       one-cycle pulse, ALUResult valid from this cycle on
//   ALUResult  result, held until the next operation completes
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; ready=1
// CALC  | DATA_WIDTH iterations of shift-add or restoring division
// FIX   | sign correction / special cases, register ALUResult, pulse done
module muldiv_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    output logic                     ready,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    ALUResult
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic           neg_a_q, neg_a_d;
    logic           neg_b_q, neg_b_d;
    logic           ovf_q, ovf_d;
    logic           dbz_q, dbz_d;
    logic [W-1:0]   orig_a_q, orig_a_d;
    // a_q: multiplicand shifted left (multiply) / dividend-quotient shifter (divide)
    logic [2*W-1:0] a_q, a_d;
    // b_q: multiplier shifted right (multiply) / divisor magnitude (divide)
    logic [W-1:0]   b_q, b_d;
    // acc_q: product (multiply) / partial remainder in acc_q[W:0] (divide)
    logic [2*W-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   result_q, result_d;
    logic           done_q, done_d;

    // Operand decode at acceptance
    logic [2:0]   op_in;
    logic         signed_a_in, signed_b_in;
    logic         neg_a_in, neg_b_in;
    logic [W-1:0] a_mag_in, b_mag_in;
    logic         ovf_in;

    assign op_in       = Operation[2:0];
    assign signed_a_in = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                         (op_in == OP_DIV)  || (op_in == OP_REM);
    assign signed_b_in = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    assign neg_a_in    = signed_a_in && SrcA[W-1];
    assign neg_b_in    = signed_b_in && SrcB[W-1];
    assign a_mag_in    = neg_a_in ? -SrcA : SrcA;
    assign b_mag_in    = neg_b_in ? -SrcB : SrcB;
    assign ovf_in      = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                         (SrcA == MOST_NEG) && (SrcB == {W{1'b1}});

    // Restoring division step: shift the next dividend bit into the partial
    // remainder and try to subtract the divisor. The partial remainder is
    // always below the divisor, so the difference fits in W bits when
    // non-negative and its top bit acts as the borrow.
    logic [W:0] rem_shift;
    logic [W:0] rem_diff;
    logic       q_bit;

    assign rem_shift = {acc_q[W-1:0], a_q[W-1]};
    assign rem_diff  = rem_shift - {1'b0, b_q};
    assign q_bit     = ~rem_diff[W];

    // Fix-up: sign correction of the magnitude results
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;
    logic [W-1:0]   fix_result;

    assign prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    assign quo_fix  = (neg_a_q ^ neg_b_q) ? -a_q[W-1:0] : a_q[W-1:0];
    assign rem_fix  = neg_a_q ? -acc_q[W-1:0] : acc_q[W-1:0];

    always_comb begin
        fix_result = '0;
        case (op_q)
            OP_MUL: begin
                fix_result = prod_fix[W-1:0];
            end
            OP_MULH, OP_MULHSU, OP_MULHU: begin
                fix_result = prod_fix[2*W-1:W];
            end
            OP_DIV, OP_DIVU: begin
                if (dbz_q) begin
                    fix_result = {W{1'b1}};
                end else if (ovf_q) begin
                    fix_result = MOST_NEG;
                end else begin
                    fix_result = quo_fix;
                end
            end
            default: begin
                // REM / REMU
                if (dbz_q) begin
                    fix_result = orig_a_q;
                end else if (ovf_q) begin
                    fix_result = '0;
                end else begin
                    fix_result = rem_fix;
                end
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        ovf_d    = ovf_q;
        dbz_d    = dbz_q;
        orig_a_d = orig_a_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = CALC;
                    op_d     = op_in;
                    neg_a_d  = neg_a_in;
                    neg_b_d  = neg_b_in;
                    ovf_d    = ovf_in;
                    dbz_d    = (SrcB == '0);
                    orig_a_d = SrcA;
                    a_d      = {{W{1'b0}}, a_mag_in};
                    b_d      = b_mag_in;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end

            CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
                if (!op_q[2]) begin
                    if (b_q[0]) begin
                        acc_d = acc_q + a_q;
                    end
                    a_d = {a_q[2*W-2:0], 1'b0};
                    b_d = {1'b0, b_q[W-1:1]};
                end else begin
                    // Quotient bits enter at the bottom as dividend bits leave the top.
                    a_d   = {a_q[2*W-1:W], a_q[W-2:0], q_bit};
                    acc_d = {{(W-1){1'b0}}, (q_bit ? rem_diff : rem_shift)};
                end
            end

            FIX: begin
                result_d = fix_result;
                done_d   = 1'b1;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
            orig_a_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            ovf_q    <= ovf_d;
            dbz_q    <= dbz_d;
            orig_a_q <= orig_a_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign busy      = ~ready;
    assign done      = done_q;
    assign ALUResult = result_q;

endmodule
